// File: rtl/pool_window_serializer_pkg.sv
// Shared types for the 2x2 pooling window serializer: FSM states, window
// sample order and the default pixel width.
package pool_window_serializer_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_PAIR_A = 3'd1,
        ST_PAIR_B = 3'd2,
        ST_EMIT0  = 3'd3,
        ST_EMIT1  = 3'd4,
        ST_EMIT2  = 3'd5,
        ST_EMIT3  = 3'd6,
        ST_DROP   = 3'd7
    } state_e;

    // Order in which the four samples of a window leave the block.
    typedef enum logic [1:0] {
        WIN_TL = 2'd0,
        WIN_TR = 2'd1,
        WIN_BL = 2'd2,
        WIN_BR = 2'd3
    } win_pos_e;

    function automatic logic is_emit(input state_e s);
        return (s == ST_EMIT0) || (s == ST_EMIT1) || (s == ST_EMIT2) || (s == ST_EMIT3);
    endfunction

endpackage

// File: rtl/pool_window_serializer_line_buffer.sv
// One-row pixel store: synchronous write, combinational read so the top can
// register the selected pixel directly into its output.
module pool_window_serializer_line_buffer #(
    parameter int IMG_W  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pool_window_serializer.sv
// Feeds the 2x2 max-pool stage: buffers even rows, then replays each 2x2
// window as TL, TR, BL, BR on four back-to-back cycles. Bypass mode is a
// one-cycle registered pass-through.
module pool_window_serializer
    import pool_window_serializer_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pool_en,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_en,
    output logic                     out_mp,
    output logic                     frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam bit               ODD_H    = (IMG_H % 2) == 1;

    state_e            state_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  base_q;
    logic              mode_q;
    logic [DATA_W-1:0] hold_a_q, hold_b_q;
    logic [DATA_W-1:0] out_q;
    logic              out_en_q, out_mp_q, frame_done_q;
    logic              byp_last_q;

    logic              xfer, col_end, frame_end, at_start, mode_eff;
    logic [COL_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    win_pos_e          sample_sel;
    logic [DATA_W-1:0] win_sample;

    assign in_ready  = !is_emit(state_q);
    assign xfer      = in_valid && in_ready;
    assign col_end   = (col_q == COL_LAST);
    assign frame_end = col_end && (row_q == ROW_LAST);
    assign at_start  = (col_q == '0) && (row_q == '0);
    // The first pixel of a frame already runs in the newly requested mode.
    assign mode_eff  = at_start ? pool_en : mode_q;

    always_comb begin
        col_d = col_q + COL_ONE;
        row_d = row_q;
        if (col_end) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Top-row pixels sit at base (even) and base+1 (odd) of the line buffer.
    assign rd_addr = (state_q == ST_PAIR_B) ? (col_q & ~COL_ONE) : (base_q | COL_ONE);

    pool_window_serializer_line_buffer #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (xfer && (state_q == ST_FILL)),
        .wr_addr_i (col_q),
        .wr_data_i (in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        sample_sel = WIN_TL;
        case (state_q)
            ST_EMIT0: sample_sel = WIN_TR;
            ST_EMIT1: sample_sel = WIN_BL;
            ST_EMIT2: sample_sel = WIN_BR;
            default:  sample_sel = WIN_TL;
        endcase
        win_sample = rd_data;
        case (sample_sel)
            WIN_BL:  win_sample = hold_a_q;
            WIN_BR:  win_sample = hold_b_q;
            default: win_sample = rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            mode_q       <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            out_q        <= '0;
            out_en_q     <= 1'b0;
            out_mp_q     <= 1'b0;
            frame_done_q <= 1'b0;
            byp_last_q   <= 1'b0;
        end else begin
            out_en_q     <= 1'b0;
            out_mp_q     <= 1'b0;
            frame_done_q <= byp_last_q;
            byp_last_q   <= 1'b0;
            if (xfer) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            case (state_q)
                ST_FILL: begin
                    if (xfer) begin
                        if (at_start) begin
                            mode_q <= pool_en;
                        end
                        if (!mode_eff) begin
                            out_q      <= in;
                            out_en_q   <= 1'b1;
                            byp_last_q <= frame_end;
                        end else if (col_end) begin
                            state_q <= ST_PAIR_A;
                        end
                    end
                end
                ST_PAIR_A: begin
                    if (xfer) begin
                        hold_a_q <= in;
                        state_q  <= ST_PAIR_B;
                    end
                end
                ST_PAIR_B: begin
                    if (xfer) begin
                        hold_b_q <= in;
                        base_q   <= col_q & ~COL_ONE;
                        out_q    <= win_sample;
                        out_en_q <= 1'b1;
                        out_mp_q <= 1'b1;
                        state_q  <= ST_EMIT0;
                    end
                end
                ST_EMIT0, ST_EMIT1, ST_EMIT2: begin
                    out_q    <= win_sample;
                    out_en_q <= 1'b1;
                    out_mp_q <= 1'b1;
                    state_q  <= state_e'(state_q + 3'd1);
                end
                ST_EMIT3: begin
                    // Counters already advanced past the PAIR_B pixel.
                    if (col_q != '0) begin
                        state_q <= ST_PAIR_A;
                    end else if (ODD_H && (row_q == ROW_LAST)) begin
                        state_q <= ST_DROP;
                    end else begin
                        state_q      <= ST_FILL;
                        frame_done_q <= (row_q == '0);
                    end
                end
                ST_DROP: begin
                    if (xfer && frame_end) begin
                        state_q      <= ST_FILL;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign out        = out_q;
    assign out_en     = out_en_q;
    assign out_mp     = out_mp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_serializer.sv
// Bench for pool_window_serializer: two instances (4x2 and 4x3 frames), a
// frame-level reference model checked every cycle, plus directed literal cases.
module tb_pool_window_serializer;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, pen, vld, rdy, den, dmp, dfd;
    logic [1:0][7:0] din, dout;

    pool_window_serializer #(.IMG_W(W), .IMG_H(2), .DATA_W(8)) u_h2 (
        .clk(clk), .reset(rst[0]), .pool_en(pen[0]), .in(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .out(dout[0]), .out_en(den[0]), .out_mp(dmp[0]), .frame_done(dfd[0]));

    pool_window_serializer #(.IMG_W(W), .IMG_H(3), .DATA_W(8)) u_h3 (
        .clk(clk), .reset(rst[1]), .pool_en(pen[1]), .in(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .out(dout[1]), .out_en(den[1]), .out_mp(dmp[1]), .frame_done(dfd[1]));

    int checks = 0;
    int errors = 0;

    // Reference model state: pixels accepted in the frame, mode, pending window.
    int         hgt [2] = '{2, 3};
    int         n [2];
    bit         mode [2];
    int         busy [2];
    bit         fd_after [2];
    bit         bp_pend [2];
    logic [7:0] img [2][4][4];
    logic [7:0] wins [2][4];
    int         widx [2];
    logic [7:0] e_out [2];
    bit         e_en [2], e_mp [2], e_fd [2], e_rdy [2];

    int olog [2][64];
    int ocnt [2], mpcnt [2], fdcnt [2], lowcnt [2];

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int  c, r;
        bit  last;
        if (rst[k]) begin
            n[k] = 0; mode[k] = 0; busy[k] = 0; widx[k] = 4;
            fd_after[k] = 0; bp_pend[k] = 0;
            e_out[k] = 8'd0; e_en[k] = 0; e_mp[k] = 0; e_fd[k] = 0; e_rdy[k] = 1;
            return;
        end
        e_en[k] = 0; e_mp[k] = 0; e_fd[k] = 0;
        if (bp_pend[k]) begin
            e_fd[k] = 1;
            bp_pend[k] = 0;
        end
        if (busy[k] > 0) begin
            busy[k]--;
            if (widx[k] < 4) begin
                e_out[k] = wins[k][widx[k]];
                widx[k]++;
                e_en[k] = 1; e_mp[k] = 1;
            end else if (fd_after[k]) begin
                e_fd[k] = 1;
                fd_after[k] = 0;
            end
        end else if (vld[k]) begin
            c = n[k] % W;
            r = n[k] / W;
            last = (n[k] == W * hgt[k] - 1);
            if (n[k] == 0) mode[k] = pen[k];
            if (!mode[k]) begin
                e_out[k] = din[k];
                e_en[k] = 1;
                if (last) bp_pend[k] = 1;
            end else begin
                img[k][r][c] = din[k];
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    wins[k][0] = img[k][r-1][c-1];
                    wins[k][1] = img[k][r-1][c];
                    wins[k][2] = img[k][r][c-1];
                    wins[k][3] = din[k];
                    e_out[k] = wins[k][0];
                    widx[k] = 1;
                    e_en[k] = 1; e_mp[k] = 1;
                    busy[k] = 4;
                    fd_after[k] = last;
                end else if (last) begin
                    e_fd[k] = 1;
                end
            end
            n[k] = last ? 0 : n[k] + 1;
        end
        e_rdy[k] = (busy[k] == 0);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("out_en", k, int'(den[k]), int'(e_en[k]));
            chk("out_mp", k, int'(dmp[k]), int'(e_mp[k]));
            chk("frame_done", k, int'(dfd[k]), int'(e_fd[k]));
            chk("in_ready", k, int'(rdy[k]), int'(e_rdy[k]));
            chk("out", k, int'($signed(dout[k])), int'($signed(e_out[k])));
            if (den[k]) begin
                if (ocnt[k] < 64) olog[k][ocnt[k]] = int'($signed(dout[k]));
                ocnt[k]++;
                if (dmp[k]) mpcnt[k]++;
                $display("tx dut%0d out=%0d mp=%0d", k, $signed(dout[k]), dmp[k]);
            end
            if (dfd[k]) fdcnt[k]++;
            if (!rdy[k]) lowcnt[k]++;
        end
    end

    task automatic clear_log(input int k);
        ocnt[k] = 0; mpcnt[k] = 0; fdcnt[k] = 0; lowcnt[k] = 0;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int k, input int v);
        int guard = 0;
        din[k] = v[7:0];
        vld[k] = 1'b1;
        while (rdy[k] !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 20) begin
                checks++; errors++;
                $display("FAIL send_timeout dut%0d: in_ready stuck at %b, expected 1", k, rdy[k]);
                break;
            end
        end
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic expect_seq(input string nm, input int k, input int exp[8]);
        chk({nm, "_count"}, k, ocnt[k], 8);
        for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", nm, i), k, olog[k][i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 2'b11; pen = 2'b00; vld = 2'b00; din = '0;
        for (int k = 0; k < 2; k++) clear_log(k);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_en", k, int'(den[k]), 0);
            chk("rst_out_mp", k, int'(dmp[k]), 0);
            chk("rst_frame_done", k, int'(dfd[k]), 0);
            chk("rst_in_ready", k, int'(rdy[k]), 1);
            chk("rst_out", k, int'(dout[k]), 0);
        end
        rst = 2'b00;

        // Continuous 4x2 pool frame.
        pen[0] = 1'b1; clear_log(0);
        for (int v = 1; v <= 8; v++) send(0, v);
        idle(4);
        chk("t1_fd_timing", 0, int'(dfd[0]), 1);
        idle(4);
        expect_seq("t1_win", 0, '{1, 2, 5, 6, 3, 4, 7, 8});
        chk("t1_mp_count", 0, mpcnt[0], 8);
        chk("t1_frame_done", 0, fdcnt[0], 1);
        chk("t1_ready_low", 0, lowcnt[0], 8);

        // Signed extremes pass unmodified.
        clear_log(0);
        begin
            int vals[8] = '{-128, 127, -1, 0, 5, -7, -128, -128};
            for (int i = 0; i < 8; i++) send(0, vals[i]);
        end
        idle(8);
        expect_seq("t2_win", 0, '{-128, 127, 5, -7, -1, 0, -128, -128});

        // Bypass with gaps.
        pen[0] = 1'b0; clear_log(0);
        for (int v = 10; v <= 17; v++) begin
            send(0, v);
            idle($urandom_range(0, 2));
        end
        idle(4);
        expect_seq("t3_byp", 0, '{10, 11, 12, 13, 14, 15, 16, 17});
        chk("t3_mp_count", 0, mpcnt[0], 0);
        chk("t3_ready_low", 0, lowcnt[0], 0);
        chk("t3_frame_done", 0, fdcnt[0], 1);

        // Odd height: last row dropped.
        pen[1] = 1'b1; clear_log(1);
        for (int v = 1; v <= 8; v++) send(1, v);
        idle(4);
        for (int v = 9; v <= 12; v++) send(1, v);
        chk("t4_fd_timing", 1, int'(dfd[1]), 1);
        idle(8);
        expect_seq("t4_win", 1, '{1, 2, 5, 6, 3, 4, 7, 8});
        chk("t4_frame_done", 1, fdcnt[1], 1);
        chk("t4_ready_low", 1, lowcnt[1], 8);

        // Reset during EMIT1 of window 2, then a clean frame.
        pen[0] = 1'b1;
        for (int v = 1; v <= 8; v++) send(0, v);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("t5_rst_out_en", 0, int'(den[0]), 0);
        chk("t5_rst_in_ready", 0, int'(rdy[0]), 1);
        rst[0] = 1'b0; clear_log(0);
        for (int v = 21; v <= 28; v++) send(0, v);
        idle(8);
        expect_seq("t5_win", 0, '{21, 22, 25, 26, 23, 24, 27, 28});
        chk("t5_frame_done", 0, fdcnt[0], 1);

        // pool_en toggled mid-frame and in_valid gaps in PAIR_A.
        pen[0] = 1'b1; clear_log(0);
        for (int v = 1; v <= 4; v++) send(0, v);
        pen[0] = 1'b0;
        send(0, 5); send(0, 6);
        idle(7);
        send(0, 7); send(0, 8);
        idle(8);
        expect_seq("t6_win", 0, '{1, 2, 5, 6, 3, 4, 7, 8});
        chk("t6_mp_count", 0, mpcnt[0], 8);
        clear_log(0);
        for (int v = 31; v <= 38; v++) send(0, v);
        idle(4);
        expect_seq("t6_byp", 0, '{31, 32, 33, 34, 35, 36, 37, 38});
        chk("t6_byp_mp", 0, mpcnt[0], 0);

        // Randomized frames; the per-cycle model compare does the checking.
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 6; f++) begin
                pen[k] = 1'($urandom % 2);
                for (int p = 0; p < W * hgt[k]; p++) begin
                    if (f == 3 && p == 5) begin
                        rst[k] = 1'b1;
                        @(negedge clk);
                        rst[k] = 1'b0;
                        break;
                    end
                    send(k, int'($urandom));
                    if ($urandom % 4 == 0) idle($urandom_range(1, 3));
                    if ($urandom % 8 == 0) pen[k] = ~pen[k];
                end
                idle(8);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
